// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the IIR datapath (FIR and feedback stages).
package iir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRound,
        StOut
    } state_t;

    // Working width of the round/saturate helper; every accumulator in the datapath fits in it.
    localparam int unsigned RsWidth = 64;

    // Accumulator width with enough headroom that w*2^F minus N products can never wrap.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coeff_w,
                                              input int unsigned taps);
        return data_w + coeff_w + $clog2(taps + 1) + 1;
    endfunction

    // Round half up, drop frac_w fraction bits, clamp to a signed data_w range.
    function automatic logic signed [RsWidth-1:0] round_sat(input logic signed [RsWidth-1:0] acc,
                                                            input int unsigned frac_w,
                                                            input int unsigned data_w,
                                                            output logic ovf);
        logic signed [RsWidth-1:0] one;
        logic signed [RsWidth-1:0] half;
        logic signed [RsWidth-1:0] rnd;
        logic signed [RsWidth-1:0] max_v;
        logic signed [RsWidth-1:0] min_v;
        logic signed [RsWidth-1:0] res;
        one   = {{(RsWidth-1){1'b0}}, 1'b1};
        half  = (frac_w == 0) ? '0 : (one <<< (frac_w - 1));
        rnd   = (acc + half) >>> frac_w;
        max_v = (one <<< (data_w - 1)) - one;
        min_v = -(one <<< (data_w - 1));
        ovf   = 1'b0;
        res   = rnd;
        if (rnd > max_v) begin
            res = max_v;
            ovf = 1'b1;
        end else if (rnd < min_v) begin
            res = min_v;
            ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_feedback_if.sv
// Sample-in / sample-out handshake bundle of the IIR feedback section.
interface iir_feedback_if #(
    parameter int unsigned OUTPUT_TAPS = 2,
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned COEFF_WIDTH = 18
);
    logic signed [DATA_WIDTH-1:0]  w_i;
    logic signed [COEFF_WIDTH-1:0] coeff_y_i [0:OUTPUT_TAPS-1];
    logic                          valid_i;
    logic                          ready_and_o;
    logic signed [DATA_WIDTH-1:0]  y_o;
    logic                          valid_o;
    logic                          ready_and_i;
    logic                          overflow_o;

    // The filter block.
    modport slave (
        input  w_i, coeff_y_i, valid_i, ready_and_i,
        output ready_and_o, y_o, valid_o, overflow_o
    );

    // The upstream/downstream environment.
    modport master (
        output w_i, coeff_y_i, valid_i, ready_and_i,
        input  ready_and_o, y_o, valid_o, overflow_o
    );
endinterface

// File: rtl/multiplier_wrapper.sv
// Signed multiplier with LATENCY register stages; USE_IP moves the first stage onto the
// operands, matching DSP input registers.
module multiplier_wrapper #(
    parameter bit          USE_IP  = 1'b0,
    parameter int unsigned A_WIDTH = 24,
    parameter int unsigned B_WIDTH = 18,
    parameter int unsigned LATENCY = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic signed [A_WIDTH-1:0]        a_i,
    input  logic signed [B_WIDTH-1:0]        b_i,
    output logic signed [A_WIDTH+B_WIDTH-1:0] p_o
);
    localparam int unsigned PWidth    = A_WIDTH + B_WIDTH;
    localparam bit          InReg     = USE_IP && (LATENCY > 0);
    localparam int unsigned OutStages = InReg ? LATENCY - 1 : LATENCY;

    logic signed [A_WIDTH-1:0] a_m;
    logic signed [B_WIDTH-1:0] b_m;
    logic signed [PWidth-1:0]  prod;

    // Without any register stage the clock and reset are not needed.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;

    if (InReg) begin : g_in_reg
        logic signed [A_WIDTH-1:0] a_q;
        logic signed [B_WIDTH-1:0] b_q;
        // Operand registers.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                a_q <= a_i;
                b_q <= b_i;
            end
        end
        assign a_m = a_q;
        assign b_m = b_q;
    end else begin : g_in_comb
        assign a_m = a_i;
        assign b_m = b_i;
    end

    assign prod = PWidth'(a_m) * PWidth'(b_m);

    if (OutStages == 0) begin : g_out_comb
        assign p_o = prod;
    end else begin : g_out_reg
        logic signed [PWidth-1:0] pipe_q [OutStages];
        // Product pipeline.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(OutStages); i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= prod;
                for (int i = 1; i < int'(OutStages); i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign p_o = pipe_q[OutStages-1];
    end
endmodule

// File: rtl/iir_feedback.sv
// Recursive IIR section: y[n] = w[n] - sum a_k*y[n-k], one shared multiplier, rounded and
// saturated, with valid/ready handshakes on both sides.
module iir_feedback
    import iir_pkg::*;
#(
    parameter int unsigned OUTPUT_TAPS      = 2,
    parameter int unsigned DATA_WIDTH       = 24,
    parameter int unsigned COEFF_WIDTH      = 18,
    parameter int unsigned COEFF_FRAC_WIDTH = 15,
    parameter int unsigned MULT_LATENCY     = 0
) (
    input logic           clk_i,
    input logic           rst_i,
    iir_feedback_if.slave bus_io
);
    localparam int unsigned AccWidth  = acc_width(DATA_WIDTH, COEFF_WIDTH, OUTPUT_TAPS);
    localparam int unsigned ProdWidth = DATA_WIDTH + COEFF_WIDTH;
    localparam int unsigned MacCycles = OUTPUT_TAPS + MULT_LATENCY;
    localparam int unsigned CntWidth  = $clog2(MacCycles + 1);

    state_t                        state_q, state_d;
    logic [CntWidth-1:0]           cnt_q, cnt_d;
    logic signed [AccWidth-1:0]    acc_q, acc_d;
    logic signed [COEFF_WIDTH-1:0] coeff_q [OUTPUT_TAPS];
    logic signed [COEFF_WIDTH-1:0] coeff_d [OUTPUT_TAPS];
    logic signed [DATA_WIDTH-1:0]  hist_q [OUTPUT_TAPS];
    logic signed [DATA_WIDTH-1:0]  hist_d [OUTPUT_TAPS];
    logic signed [DATA_WIDTH-1:0]  y_q, y_d;
    logic                          valid_q, valid_d;
    logic                          ovf_q, ovf_d;
    logic                          ready_q, ready_d;

    logic signed [DATA_WIDTH-1:0]  mul_a;
    logic signed [COEFF_WIDTH-1:0] mul_b;
    logic signed [ProdWidth-1:0]   mul_p;
    logic signed [RsWidth-1:0]     rs_full;
    logic                          rs_ovf;

    // The result is already clamped to DATA_WIDTH, so its upper bits carry only sign.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_full[RsWidth-1:DATA_WIDTH];

    // Select tap k = cnt+1; counts past the last tap (multiplier drain) feed zeros.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int k = 0; k < int'(OUTPUT_TAPS); k++) begin
            if (cnt_q == CntWidth'(k)) begin
                mul_a = hist_q[k];
                mul_b = coeff_q[k];
            end
        end
    end

    multiplier_wrapper #(
        .USE_IP  (1'b0),
        .A_WIDTH (DATA_WIDTH),
        .B_WIDTH (COEFF_WIDTH),
        .LATENCY (MULT_LATENCY)
    ) u_mult (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (mul_p)
    );

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        coeff_d = coeff_q;
        hist_d  = hist_q;
        y_d     = y_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        rs_full = round_sat(RsWidth'(acc_q), COEFF_FRAC_WIDTH, DATA_WIDTH, rs_ovf);

        case (state_q)
            StIdle: begin
                if (bus_io.valid_i && ready_q) begin
                    acc_d   = AccWidth'(bus_io.w_i) <<< COEFF_FRAC_WIDTH;
                    coeff_d = bus_io.coeff_y_i;
                    cnt_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                // Products appear MULT_LATENCY cycles after their operands were selected.
                if (int'(cnt_q) >= int'(MULT_LATENCY)) begin
                    acc_d = acc_q - AccWidth'(mul_p);
                end
                if (int'(cnt_q) == int'(MacCycles) - 1) begin
                    state_d = StRound;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRound: begin
                y_d       = rs_full[DATA_WIDTH-1:0];
                hist_d[0] = rs_full[DATA_WIDTH-1:0];
                for (int k = 1; k < int'(OUTPUT_TAPS); k++) hist_d[k] = hist_q[k-1];
                valid_d   = 1'b1;
                ovf_d     = rs_ovf;
                state_d   = StOut;
            end
            StOut: begin
                if (valid_q && bus_io.ready_and_i) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
    end

    // State and datapath registers; reset drops any in-flight sample and clears history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < int'(OUTPUT_TAPS); k++) begin
                coeff_q[k] <= '0;
                hist_q[k]  <= '0;
            end
            y_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            coeff_q <= coeff_d;
            hist_q  <= hist_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    assign bus_io.ready_and_o = ready_q;
    assign bus_io.y_o         = y_q;
    assign bus_io.valid_o     = valid_q;
    assign bus_io.overflow_o  = ovf_q;
endmodule

// File: tb/tb_iir_feedback.sv
// Self-checking bench for iir_feedback: vector table through a scoreboard queue, plus
// backpressure and mid-operation reset sequences.
module tb_iir_feedback;
    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 24;
    localparam int unsigned CW  = 18;
    localparam int unsigned FW  = 15;
    localparam int unsigned ML  = 0;
    localparam int          LAT = N + ML + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iir_feedback_if #(.OUTPUT_TAPS(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

    iir_feedback #(
        .OUTPUT_TAPS      (N),
        .DATA_WIDTH       (DW),
        .COEFF_WIDTH      (CW),
        .COEFF_FRAC_WIDTH (FW),
        .MULT_LATENCY     (ML)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    typedef struct {
        int w;
        int a1;
        int a2;
        int y;
        bit ovf;
    } vec_t;

    typedef struct {
        int y;
        bit ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int w, input int a1, input int a2, input int y, input bit ovf);
        vecs.push_back('{w: w, a1: a1, a2: a2, y: y, ovf: ovf});
    endtask

    // Wait (bounded) for ready, then present one sample for exactly one accepting edge.
    task automatic send(input int w, input int a1, input int a2);
        int t = 0;
        while (bus.ready_and_o !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ready_wait", bus.ready_and_o, 1);
        bus.w_i          = DW'(w);
        bus.coeff_y_i[0] = CW'(a1);
        bus.coeff_y_i[1] = CW'(a2);
        bus.valid_i      = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        check("ready_drop", bus.ready_and_o, 0);
    endtask

    // Wait (bounded) for valid_o, compare against the scoreboard head; leaves the bench
    // in the cycle where valid_o was first seen.
    task automatic wait_out(input string name);
        int   t = 0;
        exp_t e;
        while (bus.valid_o !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_valid"}, bus.valid_o, 1);
        check({name, "_latency"}, t, LAT);
        check({name, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_y"}, bus.y_o, e.y);
            check({name, "_ovf"}, bus.overflow_o, e.ovf);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.w_i         = '0;
        bus.coeff_y_i[0] = '0;
        bus.coeff_y_i[1] = '0;
        bus.valid_i     = 1'b0;
        bus.ready_and_i = 1'b1;

        // History runs through the whole table; expected values account for it.
        add(1000,     -16384,  0,      1000,     1'b0);
        add(0,        -16384,  0,      500,      1'b0);
        add(0,        -16384,  0,      250,      1'b0);
        add(0,        -16384,  0,      125,      1'b0);
        add(1000,     0,       0,      1000,     1'b0);
        add(3,        0,       0,      3,        1'b0);
        add(0,        -16384,  0,      2,        1'b0);
        add(-3,       0,       0,      -3,       1'b0);
        add(0,        -16384,  0,      -1,       1'b0);
        add(10,       0,       -32768, 7,        1'b0);
        add(100,      16384,   8192,   97,       1'b0);
        add(0,        0,       0,      0,        1'b0);
        add(8388607,  -32768,  0,      8388607,  1'b0);
        add(8388607,  -32768,  0,      8388607,  1'b1);
        add(0,        0,       0,      0,        1'b0);
        add(0,        0,       0,      0,        1'b0);
        add(-8388608, -32768,  0,      -8388608, 1'b0);
        add(-8388608, -32768,  0,      -8388608, 1'b1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.ready_and_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_y", bus.y_o, 0);
        check("rst_ovf", bus.overflow_o, 0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", bus.ready_and_o, 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", bus.ready_and_o, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            sb.push_back('{y: vecs[i].y, ovf: vecs[i].ovf});
            send(vecs[i].w, vecs[i].a1, vecs[i].a2);
            wait_out($sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_handshake", i), bus.valid_o, 0);
        end

        // Backpressure: hold the output, poke valid_i, then release.
        bus.ready_and_i = 1'b0;
        sb.push_back('{y: 500, ovf: 1'b0});
        send(500, 0, 0);
        wait_out("bp");
        for (int c = 0; c < 10; c++) begin
            bus.valid_i = (c % 2 == 0);
            bus.w_i     = DW'(777);
            @(posedge clk);
            #1;
            check($sformatf("bp_y_c%0d", c), bus.y_o, 500);
            check($sformatf("bp_valid_c%0d", c), bus.valid_o, 1);
            check($sformatf("bp_ready_c%0d", c), bus.ready_and_o, 0);
        end
        bus.valid_i     = 1'b0;
        bus.ready_and_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", bus.valid_o, 0);
        check("bp_release_ready", bus.ready_and_o, 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_extra_out", bus.valid_o, 0);
        // History should be [500, -8388608]: y = 0 + 500 - 8388608.
        sb.push_back('{y: -8388108, ovf: 1'b0});
        send(0, -32768, -32768);
        wait_out("bp_hist");
        @(posedge clk);
        #1;

        // Reset mid-MAC after history holds 1000.
        sb.push_back('{y: 1000, ovf: 1'b0});
        send(1000, 0, 0);
        wait_out("pre_rst");
        @(posedge clk);
        #1;
        send(0, -16384, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", bus.ready_and_o, 0);
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_y", bus.y_o, 0);
        check("mid_rst_ovf", bus.overflow_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Both history taps must be zero, so any coefficient gives y = w = 0.
        sb.push_back('{y: 0, ovf: 1'b0});
        send(0, -16384, -32768);
        wait_out("post_rst");
        @(posedge clk);
        #1;

        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
